// File: rtl/sw_alu_hex_seq_pkg.sv
// Shared constants for the switch ALU / seven-segment display datapath:
// op codes, FSM state codes and the active-low gfedcba digit table.
package sw_hex_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CAP    = 3'd1;
    localparam logic [2:0] ST_CONV_A = 3'd2;
    localparam logic [2:0] ST_CONV_B = 3'd3;
    localparam logic [2:0] ST_CONV_R = 3'd4;
    localparam logic [2:0] ST_UPD    = 3'd5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Non-decimal nibbles never reach here in normal operation; show them blank.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) s = SEG_TAB[d];
        return s;
    endfunction

endpackage

// File: rtl/sw_alu_hex_seq_if.sv
// Switch/key inputs and display/LED outputs of the hex ALU, bundled for port use.
interface sw_alu_hex_seq_if #(
    parameter int unsigned W  = 7,
    parameter int unsigned ND = 2,
    parameter int unsigned NR = 4
) ();

    logic [W-1:0]    sw_a;
    logic [W-1:0]    sw_b;
    logic [1:0]      op;
    logic            start;
    logic            busy;
    logic            done;
    logic            ovf;
    logic            neg;
    logic [7*ND-1:0] hex_a;
    logic [7*ND-1:0] hex_b;
    logic [7*NR-1:0] hex_r;

    modport master (
        output sw_a, sw_b, op, start,
        input  busy, done, ovf, neg, hex_a, hex_b, hex_r
    );

    modport slave (
        input  sw_a, sw_b, op, start,
        output busy, done, ovf, neg, hex_a, hex_b, hex_r
    );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: RW shift cycles after start,
// then a one-cycle valid pulse with bcd stable until the next start.
module bin2bcd_seq #(
    parameter int unsigned RW = 14,
    parameter int unsigned NR = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [RW-1:0]   bin,
    output logic            busy,
    output logic            valid,
    output logic [4*NR-1:0] bcd
);

    localparam int unsigned BW = 4*NR;
    localparam int unsigned CW = $clog2(RW+1);

    logic [RW-1:0] sh_q;
    logic [BW-1:0] bcd_q;
    logic [BW-1:0] adj_c;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          valid_q;

    // Correct every digit that would overflow past 9 once doubled.
    always_comb begin
        adj_c = bcd_q;
        for (int i = 0; i < int'(NR); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (start) begin
                sh_q   <= bin;
                bcd_q  <= '0;
                cnt_q  <= CW'(RW);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                bcd_q <= {adj_c[BW-2:0], sh_q[RW-1]};
                sh_q  <= {sh_q[RW-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign bcd   = bcd_q;

endmodule

// File: rtl/sw_alu_hex_seq.sv
// Switch ALU with saturated decimal operands and sequential BCD seven-segment output.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits in each field.
module sw_alu_hex_seq #(
    parameter int unsigned W  = 7,
    parameter int unsigned ND = 2,
    parameter int unsigned NR = 4,
    parameter int unsigned RW = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    sw_alu_hex_seq_if.slave   io
);

    import sw_hex_pkg::*;

    localparam int unsigned MAXO = 10**ND - 1;
    localparam int unsigned MAXR = 10**NR - 1;
    localparam int unsigned RW1  = RW + 1;
    localparam int unsigned OW   = 4*ND;
    localparam int unsigned BW   = 4*NR;

    logic [2:0]      state_q, state_d;
    logic            eng_start_c;
    logic [RW-1:0]   eng_bin_c;
    logic            eng_busy, eng_valid;
    logic [BW-1:0]   eng_bcd;
    logic            conv_done_c;

    logic [W-1:0]    sat_a_c, sat_b_c;
    logic [RW:0]     opa_c, opb_c, res_c;
    logic            ovf_c, neg_c;
    logic [RW-1:0]   r_c;

    logic [RW-1:0]   b_q, r_q;
    logic            ovf_s_q, neg_s_q;
    logic [OW-1:0]   bcd_a_q, bcd_b_q;
    logic [BW-1:0]   bcd_r_q;

    logic            busy_q, done_q, ovf_q, neg_q;
    logic [7*ND-1:0] hex_a_q, hex_b_q;
    logic [7*NR-1:0] hex_r_q;

    // Operand field encoder; with the macro, zeros above the top nonzero digit go blank.
    function automatic logic [7*ND-1:0] seg_op(input logic [OW-1:0] bcd);
        logic [7*ND-1:0] seg;
        logic            lead;
        seg  = '1;
        lead = 1'b1;
        for (int i = int'(ND) - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            lead = lead && (bcd[4*i +: 4] == 4'd0) && (i != 0);
`else
            lead = 1'b0;
`endif
            seg[7*i +: 7] = lead ? SEG_BLANK : seg_of(bcd[4*i +: 4]);
        end
        return seg;
    endfunction

    function automatic logic [7*NR-1:0] seg_res(input logic [BW-1:0] bcd);
        logic [7*NR-1:0] seg;
        logic            lead;
        seg  = '1;
        lead = 1'b1;
        for (int i = int'(NR) - 1; i >= 0; i--) begin
`ifdef LEADING_ZERO_BLANK_EN
            lead = lead && (bcd[4*i +: 4] == 4'd0) && (i != 0);
`else
            lead = 1'b0;
`endif
            seg[7*i +: 7] = lead ? SEG_BLANK : seg_of(bcd[4*i +: 4]);
        end
        return seg;
    endfunction

    assign sat_a_c = (32'(io.sw_a) > MAXO) ? W'(MAXO) : io.sw_a;
    assign sat_b_c = (32'(io.sw_b) > MAXO) ? W'(MAXO) : io.sw_b;

    // ALU on saturated operands, evaluated during the capture cycle.
    always_comb begin
        opa_c = RW1'(sat_a_c);
        opb_c = RW1'(sat_b_c);
        res_c = '0;
        neg_c = 1'b0;
        case (io.op)
            OP_ADD:  res_c = opa_c + opb_c;
            OP_SUB: begin
                neg_c = (opa_c < opb_c);
                res_c = neg_c ? (opb_c - opa_c) : (opa_c - opb_c);
            end
            OP_MUL:  res_c = opa_c * opb_c;
            default: res_c = (opa_c > opb_c) ? opa_c : opb_c;
        endcase
        ovf_c = (res_c > RW1'(MAXR));
        r_c   = ovf_c ? RW'(MAXR) : res_c[RW-1:0];
    end

    assign conv_done_c = eng_valid && !eng_busy;

    bin2bcd_seq #(.RW(RW), .NR(NR)) u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (eng_start_c),
        .bin   (eng_bin_c),
        .busy  (eng_busy),
        .valid (eng_valid),
        .bcd   (eng_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; each store edge also launches the next conversion on the shared engine.
    always_comb begin
        state_d     = state_q;
        eng_start_c = 1'b0;
        eng_bin_c   = '0;
        case (state_q)
            ST_IDLE: if (io.start) state_d = ST_CAP;
            ST_CAP: begin
                state_d     = ST_CONV_A;
                eng_start_c = 1'b1;
                eng_bin_c   = RW'(sat_a_c);
            end
            ST_CONV_A: if (conv_done_c) begin
                state_d     = ST_CONV_B;
                eng_start_c = 1'b1;
                eng_bin_c   = b_q;
            end
            ST_CONV_B: if (conv_done_c) begin
                state_d     = ST_CONV_R;
                eng_start_c = 1'b1;
                eng_bin_c   = r_q;
            end
            ST_CONV_R: if (conv_done_c) state_d = ST_UPD;
            ST_UPD:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_q     <= '0;
            r_q     <= '0;
            ovf_s_q <= 1'b0;
            neg_s_q <= 1'b0;
            bcd_a_q <= '0;
            bcd_b_q <= '0;
            bcd_r_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            hex_a_q <= '1;
            hex_b_q <= '1;
            hex_r_q <= '1;
        end else begin
            done_q <= (state_q == ST_UPD);
            if (state_q == ST_IDLE && io.start) busy_q <= 1'b1;
            else if (state_q == ST_UPD)         busy_q <= 1'b0;
            if (state_q == ST_CAP) begin
                b_q     <= RW'(sat_b_c);
                r_q     <= r_c;
                ovf_s_q <= ovf_c;
                neg_s_q <= neg_c;
            end
            if (conv_done_c) begin
                case (state_q)
                    ST_CONV_A: bcd_a_q <= eng_bcd[OW-1:0];
                    ST_CONV_B: bcd_b_q <= eng_bcd[OW-1:0];
                    ST_CONV_R: bcd_r_q <= eng_bcd;
                    default:   ;
                endcase
            end
            if (state_q == ST_UPD) begin
                hex_a_q <= seg_op(bcd_a_q);
                hex_b_q <= seg_op(bcd_b_q);
                hex_r_q <= seg_res(bcd_r_q);
                ovf_q   <= ovf_s_q;
                neg_q   <= neg_s_q;
            end
        end
    end

    assign io.busy  = busy_q;
    assign io.done  = done_q;
    assign io.ovf   = ovf_q;
    assign io.neg   = neg_q;
    assign io.hex_a = hex_a_q;
    assign io.hex_b = hex_b_q;
    assign io.hex_r = hex_r_q;

endmodule
